// File: rtl/spram_uart_dump.sv
// spram_uart_dump: reads a block of 16-bit SPRAM words and streams them over a
// byte-wide uart tx channel (send/tx_data, gated by tx_ready).
// Optional build macro SPRAM_DUMP_HEX_EN: each word is sent as 4 ASCII hex chars
// plus a line feed instead of 2 raw bytes; the FSM and handshake are unchanged.
module spram_uart_dump #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_rdata,
  input  logic              tx_ready,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done
);

`ifdef SPRAM_DUMP_HEX_EN
  localparam int unsigned NBYTES = 5;
`else
  localparam int unsigned NBYTES = 2;
`endif
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned WAIT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_LOAD, S_SEND, S_GAP, S_NEXT, S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic [15:0]       word_q;
  logic [IDX_W-1:0]  byte_idx;
  logic [WAIT_W-1:0] wait_cnt;

  // Byte idx of a word in transmit order (high byte / MSB nibble first).
  function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic [IDX_W-1:0] idx);
`ifdef SPRAM_DUMP_HEX_EN
    logic [3:0] nib;
    case (idx)
      IDX_W'(0): nib = w[15:12];
      IDX_W'(1): nib = w[11:8];
      IDX_W'(2): nib = w[7:4];
      default:   nib = w[3:0];
    endcase
    if (idx == IDX_W'(4))   byte_sel = 8'h0A;
    else if (nib < 4'd10)   byte_sel = 8'h30 + {4'h0, nib};
    else                    byte_sel = 8'h37 + {4'h0, nib};
`else
    byte_sel = (idx == '0) ? w[15:8] : w[7:0];
`endif
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = (word_count == '0) ? S_DONE : S_RD_ISSUE;
      S_RD_ISSUE: state_next = S_RD_WAIT;
      S_RD_WAIT:  if (wait_cnt == WAIT_W'(RD_LATENCY - 1)) state_next = S_LOAD;
      S_LOAD:     state_next = S_SEND;
      S_SEND:     if (tx_ready) state_next = S_GAP;
      S_GAP:      state_next = (byte_idx == IDX_W'(NBYTES)) ? S_NEXT : S_SEND;
      S_NEXT:     state_next = (remaining == ADDR_W'(1)) ? S_DONE : S_RD_ISSUE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Byte strobe is combinational so it can never fire while the uart is not ready.
  always_comb begin
    tx_send = 1'b0;
    if (state == S_SEND) tx_send = tx_ready;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      tx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      word_q    <= '0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
    end else begin
      done     <= (state_next == S_DONE);
      busy     <= (state_next != S_IDLE);
      wait_cnt <= ((state == S_RD_WAIT) && (state_next == S_RD_WAIT)) ? wait_cnt + WAIT_W'(1) : '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= word_count;
          end
        end
        S_RD_ISSUE: ram_addr <= cur_addr;
        S_LOAD: begin
          word_q   <= ram_rdata;
          byte_idx <= '0;
          tx_data  <= byte_sel(ram_rdata, '0);
        end
        S_SEND: if (tx_ready) byte_idx <= byte_idx + IDX_W'(1);
        S_GAP:  if (byte_idx != IDX_W'(NBYTES)) tx_data <= byte_sel(word_q, byte_idx);
        S_NEXT: begin
          cur_addr  <= cur_addr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
